// File: rtl/imem_pkg.sv
// Shared response/decode types and constants for the instruction memory.
// Widths here must match the DWIDTH/AWIDTH parameters used on insn_mem.
package imem_pkg;

    localparam int IMEM_DWIDTH = 32;
    localparam int IMEM_AWIDTH = 32;
    localparam int LAT_MIN     = 1;
    localparam int LAT_MAX     = 4;
    localparam logic [IMEM_DWIDTH-1:0] ERR_DATA = '0;

    typedef struct packed {
        logic [IMEM_DWIDTH-1:0] data;
        logic                   err;
    } rsp_t;

    typedef struct packed {
        logic [IMEM_AWIDTH-1:0] idx;
        logic                   in_range;
    } dec_t;

    // Unsigned subtraction: addresses below base wrap to huge offsets, so both
    // terms of in_range are needed to reject them without relying on wrap.
    function automatic dec_t imem_decode(
        input logic [IMEM_AWIDTH-1:0] addr,
        input logic [IMEM_AWIDTH-1:0] base,
        input logic [IMEM_AWIDTH-1:0] depth_words
    );
        dec_t                   d;
        logic [IMEM_AWIDTH-1:0] offset;
        offset     = addr - base;
        d.idx      = offset >> 2;
        d.in_range = (addr >= base) && (d.idx < depth_words);
        return d;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO of rsp_t; count feeds the request credit logic.
// Push into a full FIFO or pop from an empty one is ignored.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output rsp_t          head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop here samples the pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // NOTE: storage has no reset; count is cleared instead and gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/insn_mem.sv
// Instruction memory: valid/ready fetch with fixed LATENCY, plus a word load port.
// Define IMEM_MISALIGN_ERR_EN to fault fetches with addr[1:0] != 0.
module insn_mem
    import imem_pkg::*;
#(
    parameter int               DWIDTH      = IMEM_DWIDTH,
    parameter int               AWIDTH      = IMEM_AWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR   = 32'h0100_0000,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic              load_en_i,
    input  logic [AWIDTH-1:0] load_addr_i,
    input  logic [DWIDTH-1:0] load_data_i
);

    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
    localparam int FIFO_DEPTH = LAT + 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int IDXW       = $clog2(DEPTH_WORDS);

    logic [DWIDTH-1:0] mem [DEPTH_WORDS];
    dec_t              req_dec;
    dec_t              load_dec;
    logic [IDXW-1:0]   req_idx;
    logic [IDXW-1:0]   load_idx;
    rsp_t              rd_rsp;
    logic [LAT-1:0]    pipe_valid;
    rsp_t              pipe_rsp [LAT];
    rsp_t              fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              ready_en;
    logic              accept;
    logic              retire;
    int                outstanding;

    assign req_dec  = imem_decode(req_addr_i, BASEADDR, IMEM_AWIDTH'(DEPTH_WORDS));
    assign load_dec = imem_decode(load_addr_i, BASEADDR, IMEM_AWIDTH'(DEPTH_WORDS));
    assign req_idx  = IDXW'(req_dec.idx);
    assign load_idx = IDXW'(load_dec.idx);

    // Read happens at acceptance; a load on the same edge lands afterwards.
    always_comb begin
        // NOTE: defaults first so every path assigns rd_rsp and no latch is inferred.
        rd_rsp.data = ERR_DATA;
        rd_rsp.err  = 1'b1;
        if (req_dec.in_range) begin
            rd_rsp.data = mem[req_idx];
            rd_rsp.err  = 1'b0;
        end
`ifdef IMEM_MISALIGN_ERR_EN
        if (req_addr_i[1:0] != 2'b00) begin
            rd_rsp.data = ERR_DATA;
            rd_rsp.err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (load_en_i && load_dec.in_range) mem[load_idx] <= load_data_i;
    end

    // Credit is conservative: a response retiring this cycle frees its slot next cycle.
    always_comb outstanding = int'(fifo_count) + $countones(pipe_valid);

    assign req_ready_o = ready_en && (outstanding < FIFO_DEPTH);
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (fifo_count != '0);
    assign retire      = rsp_valid_o && rsp_ready_i;
    assign rsp_data_o  = rsp_valid_o ? fifo_head.data : ERR_DATA;
    assign rsp_err_o   = rsp_valid_o && fifo_head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en   <= 1'b0;
            pipe_valid <= '0;
        end else begin
            ready_en      <= 1'b1;
            pipe_valid[0] <= accept;
            for (int i = 1; i < LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_rsp[0] <= rd_rsp;
        for (int i = 1; i < LAT; i++) pipe_rsp[i] <= pipe_rsp[i-1];
    end

    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid[LAT-1]),
        .push_data (pipe_rsp[LAT-1]),
        .pop       (retire),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule
